// File: rtl/dut_pkg.sv
// dut_pkg: shared state encoding, memory map constants and operand/product types
package dut_pkg;
  localparam int NPAIRS = 16;
  localparam int OP_BASE = 0;
  localparam int RES_BASE = 64;
  localparam int MEM_DEPTH = 256;
  typedef enum logic [2:0] {IDLE, ARMED, LOAD, MUL, STORE, DONE} state_e;
  typedef logic signed [15:0] operand_t;
  typedef logic signed [31:0] product_t;
endpackage

// File: rtl/dat_mem.sv
// dat_mem: single-port byte memory, asynchronous read, synchronous write
module dat_mem
  import dut_pkg::*;
(
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout
);
  logic [7:0] core [MEM_DEPTH];
  assign dout = core[addr];
  always_ff @(posedge clk) if (wr_en) core[addr] <= din;
endmodule

// File: rtl/dut.sv
// dut: multiplies 16 signed 16-bit operand pairs held in dm and writes 32-bit products back.
// DUT_SEQ_MULT_EN selects a 16-cycle radix-2 Booth multiplier instead of a single-cycle one.
module dut
  import dut_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic done
);
  state_e state_q, state_d;
  logic [3:0] pair_q, pair_d, cnt_q, cnt_d;
  operand_t a_q, a_d, b_q, b_d;
  product_t p_q, p_d;
  logic wr_en;
  logic [7:0] addr, din, dout;
  logic [1:0] idx;
  assign idx = cnt_q[1:0];
`ifdef DUT_SEQ_MULT_EN
  // booth_q = {accumulator[16:0], multiplier[15:0], q_minus_1}
  logic [33:0] booth_q, booth_d, booth_sh;
  logic [16:0] m, sum;
  assign m = {a_q[15], a_q};
  assign sum = booth_q[33:17] + (booth_q[1:0] == 2'b01 ? m : booth_q[1:0] == 2'b10 ? -m : 17'd0);
  assign booth_sh = {sum[16], sum, booth_q[16:1]};
`endif
  dat_mem dm (.clk(clk), .wr_en(wr_en), .addr(addr), .din(din), .dout(dout));
  assign wr_en = state_q == STORE;
  assign addr = (state_q == STORE ? 8'(RES_BASE) : 8'(OP_BASE)) + {2'b00, pair_q, idx};
  assign din = idx == 2'd0 ? p_q[31:24] : idx == 2'd1 ? p_q[23:16] : idx == 2'd2 ? p_q[15:8] : p_q[7:0];
  assign done = state_q == DONE;
  always_comb begin
    state_d = state_q;
    pair_d = pair_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    p_d = p_q;
`ifdef DUT_SEQ_MULT_EN
    booth_d = booth_q;
`endif
    case (state_q)
      IDLE: state_d = start ? ARMED : IDLE;
      ARMED: if (!start) begin
        state_d = LOAD;
        pair_d = '0;
        cnt_d = '0;
      end
      LOAD: begin
        cnt_d = cnt_q + 4'd1;
        case (idx)
          2'd0: a_d[15:8] = dout;
          2'd1: a_d[7:0] = dout;
          2'd2: b_d[15:8] = dout;
          default: b_d[7:0] = dout;
        endcase
        if (idx == 2'd3) begin
          state_d = MUL;
          cnt_d = '0;
`ifdef DUT_SEQ_MULT_EN
          booth_d = {17'd0, b_q[15:8], dout, 1'b0};
`endif
        end
      end
      MUL: begin
`ifdef DUT_SEQ_MULT_EN
        booth_d = booth_sh;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          p_d = booth_sh[32:1];
          state_d = STORE;
          cnt_d = '0;
        end
`else
        p_d = b_q * a_q;
        state_d = STORE;
`endif
      end
      STORE: begin
        cnt_d = cnt_q + 4'd1;
        if (idx == 2'd3) begin
          cnt_d = '0;
          if (pair_q == 4'(NPAIRS - 1)) state_d = DONE;
          else begin
            pair_d = pair_q + 4'd1;
            state_d = LOAD;
          end
        end
      end
      DONE: state_d = start ? ARMED : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pair_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      p_q <= '0;
`ifdef DUT_SEQ_MULT_EN
      booth_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      pair_q <= pair_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      p_q <= p_d;
`ifdef DUT_SEQ_MULT_EN
      booth_q <= booth_d;
`endif
    end
  end
endmodule

// File: tb/tb_dut.sv
// tb_dut: randomized memory images checked against a plain-arithmetic product model
module tb_dut;
  import dut_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic done;
  int checks = 0, failures = 0;
  logic [7:0] img [256];
`ifdef DUT_SEQ_MULT_EN
  localparam int LAT = 384;
`else
  localparam int LAT = 144;
`endif
  dut u_dut (.clk(clk), .rst_n(rst_n), .start(start), .done(done));
  always #5 clk = ~clk;
  function automatic logic [7:0] exp_byte(input int i);
    shortint a, b;
    int p, j4;
    if (i < 64 || i >= 128) return img[i];
    j4 = i - 64 - i % 4;
    a = {img[j4], img[j4 + 1]};
    b = {img[j4 + 2], img[j4 + 3]};
    p = int'(a) * int'(b);
    return 8'(p >> (8 * (3 - i % 4)));
  endfunction
  task automatic load_random();
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
  endtask
  task automatic set_pair(input int j, input logic [15:0] a, input logic [15:0] b);
    img[4 * j] = a[15:8];
    img[4 * j + 1] = a[7:0];
    img[4 * j + 2] = b[15:8];
    img[4 * j + 3] = b[7:0];
  endtask
  task automatic push();
    for (int i = 0; i < 256; i++) u_dut.dm.core[i] = img[i];
  endtask
  task automatic run(input bit reload, output int n, output logic d_arm);
    @(negedge clk) start = 1'b1;
    if (reload) begin
      load_random();
      push();
    end
    @(negedge clk) d_arm = done;
    start = 1'b0;
    @(posedge clk);
    n = 0;
    while (n < 2000 && done !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (u_dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d want=%0d", u_dut.state_q, IDLE); end
    checks++; if (u_dut.pair_q !== 4'd0) begin failures++; $display("FAIL reset_pair got=%0d want=0", u_dut.pair_q); end
    checks++; if ({u_dut.a_q, u_dut.b_q, u_dut.p_q} !== 64'd0) begin failures++; $display("FAIL reset_regs got=%h want=0", {u_dut.a_q, u_dut.b_q, u_dut.p_q}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (u_dut.state_q !== IDLE) begin failures++; $display("FAIL idle_after_reset got=%0d want=%0d", u_dut.state_q, IDLE); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL idle_done got=%b want=0", done); end
  endtask
  task automatic test_directed();
    int n;
    logic d;
    logic [31:0] want [5];
    logic [31:0] got;
    want = '{32'h3FFF0001, 32'h40000000, 32'hC0008000, 32'hFFFFFFFF, 32'h00000000};
    load_random();
    set_pair(0, 16'h7FFF, 16'h7FFF);
    set_pair(1, 16'h8000, 16'h8000);
    set_pair(2, 16'h8000, 16'h7FFF);
    set_pair(3, 16'hFFFF, 16'h0001);
    set_pair(4, 16'h0000, 16'h1234);
    push();
    run(1'b0, n, d);
    checks++; if (n !== LAT) begin failures++; $display("FAIL directed_latency got=%0d want=%0d", n, LAT); end
    for (int j = 0; j < 5; j++) begin
      got = {u_dut.dm.core[64 + 4 * j], u_dut.dm.core[65 + 4 * j], u_dut.dm.core[66 + 4 * j], u_dut.dm.core[67 + 4 * j]};
      checks++; if (got !== want[j]) begin failures++; $display("FAIL directed_pair%0d got=%h want=%h", j, got, want[j]); end
    end
    for (int i = 0; i < 256; i++) begin
      checks++; if (u_dut.dm.core[i] !== exp_byte(i)) begin failures++; $display("FAIL directed_mem[%0d] got=%h want=%h", i, u_dut.dm.core[i], exp_byte(i)); end
    end
  endtask
  task automatic test_random();
    int n;
    logic d;
    load_random();
    push();
    run(1'b0, n, d);
    checks++; if (d !== 1'b0) begin failures++; $display("FAIL random_done_fall got=%b want=0", d); end
    checks++; if (n !== LAT) begin failures++; $display("FAIL random_latency got=%0d want=%0d", n, LAT); end
    for (int i = 0; i < 256; i++) begin
      checks++; if (u_dut.dm.core[i] !== exp_byte(i)) begin failures++; $display("FAIL random_mem[%0d] got=%h want=%h", i, u_dut.dm.core[i], exp_byte(i)); end
    end
  endtask
  task automatic test_back_to_back();
    int n;
    logic d;
    for (int r = 0; r < 10; r++) begin
      run(1'b1, n, d);
      checks++; if (d !== 1'b0) begin failures++; $display("FAIL b2b%0d_done_fall got=%b want=0", r, d); end
      checks++; if (n !== LAT) begin failures++; $display("FAIL b2b%0d_latency got=%0d want=%0d", r, n, LAT); end
      for (int i = 0; i < 256; i++) begin
        checks++; if (u_dut.dm.core[i] !== exp_byte(i)) begin failures++; $display("FAIL b2b%0d_mem[%0d] got=%h want=%h", r, i, u_dut.dm.core[i], exp_byte(i)); end
      end
    end
  endtask
  task automatic test_abort();
    int n;
    logic d;
    load_random();
    for (int i = 64; i < 128; i++) img[i] = 8'hA5;
    push();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(posedge clk);
    repeat (50) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b want=0", done); end
    checks++; if (u_dut.state_q !== IDLE) begin failures++; $display("FAIL abort_state got=%0d want=%0d", u_dut.state_q, IDLE); end
    // pairs 0..4 finished before the abort, pair 5 had not started storing, the rest untouched
    for (int i = 0; i < 256; i++) begin
      if (i < 84 || i >= 128) begin
        checks++; if (u_dut.dm.core[i] !== exp_byte(i)) begin failures++; $display("FAIL abort_mem[%0d] got=%h want=%h", i, u_dut.dm.core[i], exp_byte(i)); end
      end else if (i >= 88) begin
        checks++; if (u_dut.dm.core[i] !== 8'hA5) begin failures++; $display("FAIL abort_unwritten[%0d] got=%h want=a5", i, u_dut.dm.core[i]); end
      end
    end
    @(negedge clk) rst_n = 1'b1;
    run(1'b0, n, d);
    checks++; if (n !== LAT) begin failures++; $display("FAIL after_abort_latency got=%0d want=%0d", n, LAT); end
    for (int i = 0; i < 256; i++) begin
      checks++; if (u_dut.dm.core[i] !== exp_byte(i)) begin failures++; $display("FAIL after_abort_mem[%0d] got=%h want=%h", i, u_dut.dm.core[i], exp_byte(i)); end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
